// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: dual-slot in-order issue control with INT/FP register scoreboards
module decode_issue_ctrl #(
  parameter logic [5:0] DUAL_UNIT_MASK = 6'b000011,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            inst0_valid_i,
  input  logic            inst0_rs1_valid_i,
  input  logic            inst0_rs2_valid_i,
  input  logic            inst0_rs3_valid_i,
  input  logic [4:0]      inst0_rs1_i,
  input  logic [4:0]      inst0_rs2_i,
  input  logic [4:0]      inst0_rs3_i,
  input  logic [2:0]      inst0_rs_fp_i,
  input  logic [1:0]      inst0_rd_type_i,
  input  logic [4:0]      inst0_rd_i,
  input  logic [5:0]      inst0_exe_unit_i,
  input  logic            inst1_valid_i,
  input  logic            inst1_rs1_valid_i,
  input  logic            inst1_rs2_valid_i,
  input  logic            inst1_rs3_valid_i,
  input  logic [4:0]      inst1_rs1_i,
  input  logic [4:0]      inst1_rs2_i,
  input  logic [4:0]      inst1_rs3_i,
  input  logic [2:0]      inst1_rs_fp_i,
  input  logic [1:0]      inst1_rd_type_i,
  input  logic [4:0]      inst1_rd_i,
  input  logic [5:0]      inst1_exe_unit_i,
  input  logic            wb0_valid_i,
  input  logic [1:0]      wb0_rd_type_i,
  input  logic [4:0]      wb0_rd_i,
  input  logic            wb1_valid_i,
  input  logic [1:0]      wb1_rd_type_i,
  input  logic [4:0]      wb1_rd_i,
  output logic            issue0_o,
  output logic            issue1_o,
  output logic            stall_decoder_inst0_o,
  output logic            stall_decoder_inst1_o,
  output logic [NREG-1:0] int_busy_o,
  output logic [NREG-1:0] fp_busy_o
);
  logic [NREG-1:0] int_busy, fp_busy, int_clr, fp_clr, int_set, fp_set;
  logic done0, ok0, ok1, pair_ok, ready1, issue0, issue1, stall0;
  logic d0_int, d0_fp, d1_int, d1_fp;

  function automatic logic src_ok(logic v, logic fp, logic [4:0] r, logic [NREG-1:0] ib, logic [NREG-1:0] fb);
    return !v || !(fp ? fb[r] : ib[r]);
  endfunction

  function automatic logic rd_ok(logic [1:0] t, logic [4:0] r, logic [NREG-1:0] ib, logic [NREG-1:0] fb);
    return t == 2'b01 ? !ib[r] : t == 2'b10 ? !fb[r] : 1'b1;
  endfunction

  always_comb begin
    d0_int = inst0_rd_type_i == 2'b01 && inst0_rd_i != 5'd0;
    d0_fp = inst0_rd_type_i == 2'b10;
    d1_int = inst1_rd_type_i == 2'b01 && inst1_rd_i != 5'd0;
    d1_fp = inst1_rd_type_i == 2'b10;
    ok0 = src_ok(inst0_rs1_valid_i, inst0_rs_fp_i[0], inst0_rs1_i, int_busy, fp_busy) &&
          src_ok(inst0_rs2_valid_i, inst0_rs_fp_i[1], inst0_rs2_i, int_busy, fp_busy) &&
          src_ok(inst0_rs3_valid_i, inst0_rs_fp_i[2], inst0_rs3_i, int_busy, fp_busy) &&
          rd_ok(inst0_rd_type_i, inst0_rd_i, int_busy, fp_busy);
    ok1 = src_ok(inst1_rs1_valid_i, inst1_rs_fp_i[0], inst1_rs1_i, int_busy, fp_busy) &&
          src_ok(inst1_rs2_valid_i, inst1_rs_fp_i[1], inst1_rs2_i, int_busy, fp_busy) &&
          src_ok(inst1_rs3_valid_i, inst1_rs_fp_i[2], inst1_rs3_i, int_busy, fp_busy) &&
          rd_ok(inst1_rd_type_i, inst1_rd_i, int_busy, fp_busy);
    pair_ok = !(inst1_rs1_valid_i && inst1_rs1_i == inst0_rd_i && (inst1_rs_fp_i[0] ? d0_fp : d0_int)) &&
              !(inst1_rs2_valid_i && inst1_rs2_i == inst0_rd_i && (inst1_rs_fp_i[1] ? d0_fp : d0_int)) &&
              !(inst1_rs3_valid_i && inst1_rs3_i == inst0_rd_i && (inst1_rs_fp_i[2] ? d0_fp : d0_int)) &&
              !((d1_int && d0_int || d1_fp && d0_fp) && inst1_rd_i == inst0_rd_i) &&
              !(inst0_exe_unit_i == inst1_exe_unit_i && (inst0_exe_unit_i & DUAL_UNIT_MASK) == 6'd0);
    issue0 = rst_n && !flush_i && inst0_valid_i && !done0 && ok0;
    ready1 = ok1 && (!inst0_valid_i || done0 || issue0) && (!issue0 || pair_ok);
    issue1 = rst_n && !flush_i && inst1_valid_i && ready1;
    stall0 = rst_n && !flush_i && (inst0_valid_i && !done0 && !issue0 || inst1_valid_i && !issue1);
    int_clr = (wb0_valid_i && wb0_rd_type_i == 2'b01 ? NREG'(1) << wb0_rd_i : '0) |
              (wb1_valid_i && wb1_rd_type_i == 2'b01 ? NREG'(1) << wb1_rd_i : '0);
    fp_clr = (wb0_valid_i && wb0_rd_type_i == 2'b10 ? NREG'(1) << wb0_rd_i : '0) |
             (wb1_valid_i && wb1_rd_type_i == 2'b10 ? NREG'(1) << wb1_rd_i : '0);
    int_set = (issue0 && d0_int ? NREG'(1) << inst0_rd_i : '0) | (issue1 && d1_int ? NREG'(1) << inst1_rd_i : '0);
    fp_set = (issue0 && d0_fp ? NREG'(1) << inst0_rd_i : '0) | (issue1 && d1_fp ? NREG'(1) << inst1_rd_i : '0);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      int_busy <= '0;
      fp_busy <= '0;
      done0 <= 1'b0;
    end else if (flush_i) begin
      int_busy <= '0;
      fp_busy <= '0;
      done0 <= 1'b0;
    end else begin
      int_busy <= int_busy & ~int_clr | int_set;
      fp_busy <= fp_busy & ~fp_clr | fp_set;
      done0 <= stall0 && (issue0 || done0);
    end

  assign issue0_o = issue0;
  assign issue1_o = issue1;
  assign stall_decoder_inst0_o = stall0;
  assign stall_decoder_inst1_o = !issue1;
  assign int_busy_o = int_busy;
  assign fp_busy_o = fp_busy;
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: directed vectors with a queued scoreboard checked at the falling edge
module tb_decode_issue_ctrl;
  localparam logic [5:0] ALU = 6'b000001;
  localparam logic [5:0] LSU = 6'b010000;
  logic clk = 1'b0, rst_n, flush_i;
  logic inst0_valid_i, inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i;
  logic [4:0] inst0_rs1_i, inst0_rs2_i, inst0_rs3_i, inst0_rd_i;
  logic [2:0] inst0_rs_fp_i;
  logic [1:0] inst0_rd_type_i;
  logic [5:0] inst0_exe_unit_i;
  logic inst1_valid_i, inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i;
  logic [4:0] inst1_rs1_i, inst1_rs2_i, inst1_rs3_i, inst1_rd_i;
  logic [2:0] inst1_rs_fp_i;
  logic [1:0] inst1_rd_type_i;
  logic [5:0] inst1_exe_unit_i;
  logic wb0_valid_i, wb1_valid_i;
  logic [1:0] wb0_rd_type_i, wb1_rd_type_i;
  logic [4:0] wb0_rd_i, wb1_rd_i;
  logic issue0_o, issue1_o, stall_decoder_inst0_o, stall_decoder_inst1_o;
  logic [31:0] int_busy_o, fp_busy_o;

  typedef struct packed {
    logic i0, i1, s0, s1;
    logic [31:0] ib, fb;
  } exp_t;
  exp_t exp_q[$];
  string name_q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  decode_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .inst0_valid_i(inst0_valid_i), .inst0_rs1_valid_i(inst0_rs1_valid_i),
    .inst0_rs2_valid_i(inst0_rs2_valid_i), .inst0_rs3_valid_i(inst0_rs3_valid_i),
    .inst0_rs1_i(inst0_rs1_i), .inst0_rs2_i(inst0_rs2_i), .inst0_rs3_i(inst0_rs3_i),
    .inst0_rs_fp_i(inst0_rs_fp_i), .inst0_rd_type_i(inst0_rd_type_i), .inst0_rd_i(inst0_rd_i),
    .inst0_exe_unit_i(inst0_exe_unit_i),
    .inst1_valid_i(inst1_valid_i), .inst1_rs1_valid_i(inst1_rs1_valid_i),
    .inst1_rs2_valid_i(inst1_rs2_valid_i), .inst1_rs3_valid_i(inst1_rs3_valid_i),
    .inst1_rs1_i(inst1_rs1_i), .inst1_rs2_i(inst1_rs2_i), .inst1_rs3_i(inst1_rs3_i),
    .inst1_rs_fp_i(inst1_rs_fp_i), .inst1_rd_type_i(inst1_rd_type_i), .inst1_rd_i(inst1_rd_i),
    .inst1_exe_unit_i(inst1_exe_unit_i),
    .wb0_valid_i(wb0_valid_i), .wb0_rd_type_i(wb0_rd_type_i), .wb0_rd_i(wb0_rd_i),
    .wb1_valid_i(wb1_valid_i), .wb1_rd_type_i(wb1_rd_type_i), .wb1_rd_i(wb1_rd_i),
    .issue0_o(issue0_o), .issue1_o(issue1_o),
    .stall_decoder_inst0_o(stall_decoder_inst0_o), .stall_decoder_inst1_o(stall_decoder_inst1_o),
    .int_busy_o(int_busy_o), .fp_busy_o(fp_busy_o)
  );

  always @(negedge clk)
    if (exp_q.size() != 0) begin
      exp_t e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{issue0_o, issue1_o, stall_decoder_inst0_o, stall_decoder_inst1_o, int_busy_o, fp_busy_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got i0=%b i1=%b st0=%b st1=%b int=%h fp=%h, expected i0=%b i1=%b st0=%b st1=%b int=%h fp=%h",
                 n, a.i0, a.i1, a.s0, a.s1, a.ib, a.fb, e.i0, e.i1, e.s0, e.s1, e.ib, e.fb);
      end
    end

  task automatic idle();
    flush_i = 0;
    {inst0_valid_i, inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i} = '0;
    {inst0_rs1_i, inst0_rs2_i, inst0_rs3_i, inst0_rd_i, inst0_rs_fp_i, inst0_rd_type_i, inst0_exe_unit_i} = '0;
    {inst1_valid_i, inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i} = '0;
    {inst1_rs1_i, inst1_rs2_i, inst1_rs3_i, inst1_rd_i, inst1_rs_fp_i, inst1_rd_type_i, inst1_exe_unit_i} = '0;
    {wb0_valid_i, wb0_rd_type_i, wb0_rd_i, wb1_valid_i, wb1_rd_type_i, wb1_rd_i} = '0;
  endtask

  task automatic s0(logic r1v, logic [4:0] r1, logic r2v, logic [4:0] r2, logic [2:0] fp,
                    logic [1:0] rdt, logic [4:0] rd, logic [5:0] exe);
    inst0_valid_i = 1; inst0_rs1_valid_i = r1v; inst0_rs1_i = r1; inst0_rs2_valid_i = r2v; inst0_rs2_i = r2;
    inst0_rs_fp_i = fp; inst0_rd_type_i = rdt; inst0_rd_i = rd; inst0_exe_unit_i = exe;
  endtask

  task automatic s1(logic r1v, logic [4:0] r1, logic r2v, logic [4:0] r2, logic [2:0] fp,
                    logic [1:0] rdt, logic [4:0] rd, logic [5:0] exe);
    inst1_valid_i = 1; inst1_rs1_valid_i = r1v; inst1_rs1_i = r1; inst1_rs2_valid_i = r2v; inst1_rs2_i = r2;
    inst1_rs_fp_i = fp; inst1_rd_type_i = rdt; inst1_rd_i = rd; inst1_exe_unit_i = exe;
  endtask

  task automatic wb(int m, logic [1:0] t, logic [4:0] r);
    if (m == 0) begin wb0_valid_i = 1; wb0_rd_type_i = t; wb0_rd_i = r; end
    else begin wb1_valid_i = 1; wb1_rd_type_i = t; wb1_rd_i = r; end
  endtask

  task automatic chk(string n, logic i0, logic i1, logic st0, logic st1, logic [31:0] ib, logic [31:0] fb);
    exp_q.push_back('{i0, i1, st0, st1, ib, fb});
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    @(posedge clk);
    #1;
    s0(0, 0, 0, 0, 3'b000, 2'b01, 1, ALU);
    chk("reset", 0, 0, 0, 1, 0, 0);
    rst_n = 1;
    // independent dual-ALU pair
    idle(); s0(1, 10, 0, 0, 3'b000, 2'b01, 1, ALU); s1(1, 11, 0, 0, 3'b000, 2'b01, 2, ALU);
    chk("indep_pair", 1, 1, 0, 0, 0, 0);
    idle(); chk("indep_busy", 0, 0, 0, 1, 32'h6, 0);
    idle(); wb(0, 2'b01, 1); wb(1, 2'b01, 2);
    chk("wb_no_bypass", 0, 0, 0, 1, 32'h6, 0);
    idle(); chk("wb_cleared", 0, 0, 0, 1, 0, 0);
    // intra-pair RAW on x5
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b01, 5, ALU); s1(1, 5, 0, 0, 3'b000, 2'b01, 6, ALU);
    chk("raw_c0", 1, 0, 1, 1, 0, 0);
    chk("raw_c1", 0, 0, 1, 1, 32'h20, 0);
    chk("raw_c2", 0, 0, 1, 1, 32'h20, 0);
    wb(0, 2'b01, 5);
    chk("raw_c3_wb", 0, 0, 1, 1, 32'h20, 0);
    wb0_valid_i = 0;
    chk("raw_c4", 0, 1, 0, 0, 0, 0);
    idle(); chk("raw_c5", 0, 0, 0, 1, 32'h40, 0);
    idle(); wb(1, 2'b01, 6); chk("raw_wb6", 0, 0, 0, 1, 32'h40, 0);
    // same-cycle WAW, then FP rd does not collide with INT source
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b01, 12, ALU); s1(0, 0, 0, 0, 3'b000, 2'b01, 12, ALU);
    chk("pair_waw", 1, 0, 1, 1, 0, 0);
    idle(); wb(0, 2'b01, 12); chk("pair_waw_busy", 0, 0, 0, 1, 32'h1000, 0);
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b10, 4, ALU); s1(1, 4, 0, 0, 3'b000, 2'b00, 0, ALU);
    chk("fp_int_nocollide", 1, 1, 0, 0, 0, 0);
    idle(); wb(1, 2'b10, 4); chk("fp_busy4", 0, 0, 0, 1, 0, 32'h10);
    // slot 0 blocked on busy x3
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b01, 3, ALU);
    chk("set_x3", 1, 0, 0, 1, 0, 0);
    idle(); s0(0, 0, 1, 3, 3'b000, 2'b01, 8, ALU); s1(0, 0, 0, 0, 3'b000, 2'b01, 9, ALU);
    chk("blk_c0", 0, 0, 1, 1, 32'h8, 0);
    wb(1, 2'b01, 3);
    chk("blk_wb", 0, 0, 1, 1, 32'h8, 0);
    wb1_valid_i = 0;
    chk("blk_go", 1, 1, 0, 0, 0, 0);
    idle(); wb(0, 2'b01, 8); wb(1, 2'b01, 9); chk("blk_busy", 0, 0, 0, 1, 32'h300, 0);
    // structural hazard on a single-instance unit
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b01, 10, LSU); s1(0, 0, 0, 0, 3'b000, 2'b01, 11, LSU);
    chk("struct_c0", 1, 0, 1, 1, 0, 0);
    chk("struct_c1", 0, 1, 0, 0, 32'h400, 0);
    idle(); wb(0, 2'b01, 10); wb(1, 2'b01, 11); chk("struct_busy", 0, 0, 0, 1, 32'hC00, 0);
    // set beats clear, x0, FP f0, WAW and source checks
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b01, 7, ALU); wb(1, 2'b01, 7);
    chk("set_wins", 1, 0, 0, 1, 0, 0);
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b01, 0, ALU);
    chk("x0_issue", 1, 0, 0, 1, 32'h80, 0);
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b01, 7, ALU);
    chk("waw_block", 0, 0, 1, 1, 32'h80, 0);
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b10, 0, ALU);
    chk("fp_f0_issue", 1, 0, 0, 1, 32'h80, 0);
    idle(); s0(0, 0, 0, 0, 3'b100, 2'b00, 0, ALU); inst0_rs3_valid_i = 1; inst0_rs3_i = 0;
    chk("rs3_fp_block", 0, 0, 1, 1, 32'h80, 32'h1);
    idle(); s0(1, 0, 0, 0, 3'b000, 2'b00, 0, ALU);
    chk("int_x0_src", 1, 0, 0, 1, 32'h80, 32'h1);
    idle(); wb(0, 2'b01, 7); wb(1, 2'b10, 0);
    chk("wb_mixed", 0, 0, 0, 1, 32'h80, 32'h1);
    // flush with done0 set
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b10, 0, ALU); s1(0, 0, 0, 0, 3'b000, 2'b10, 1, ALU);
    chk("fp_pair", 1, 1, 0, 0, 0, 0);
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b01, 1, LSU); s1(0, 0, 0, 0, 3'b000, 2'b01, 2, LSU);
    chk("pre_flush", 1, 0, 1, 1, 0, 32'h3);
    flush_i = 1;
    chk("flush", 0, 0, 0, 1, 32'h2, 32'h3);
    idle(); chk("post_flush", 0, 0, 0, 1, 0, 0);
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b01, 1, ALU);
    chk("done0_cleared", 1, 0, 0, 1, 0, 0);
    // asynchronous reset in the middle of a held pair
    idle(); s0(0, 0, 0, 0, 3'b000, 2'b01, 3, LSU); s1(0, 0, 0, 0, 3'b000, 2'b01, 4, LSU);
    chk("pre_rst", 1, 0, 1, 1, 32'h2, 0);
    rst_n = 0;
    chk("async_rst", 0, 0, 0, 1, 0, 0);
    rst_n = 1;
    chk("after_rst", 1, 0, 1, 1, 0, 0);
    idle(); chk("final", 0, 0, 0, 1, 32'h8, 0);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
